// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: read-modify-write sequencer for a bank of csr registers.
// Each request is read, merged (write/set/clear), strobed back and answered with the old value.
module csr_access_ctrl #(
   parameter int Width   = 32,
   parameter int NumRegs = 8,
   parameter int AddrW   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [1:0]               req_op_i,
   input  logic [AddrW-1:0]         req_addr_i,
   input  logic [Width-1:0]         req_data_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [Width-1:0]         rsp_rdata_o,
   output logic                     rsp_err_o,
   output logic [NumRegs-1:0]       csr_wr_en_o,
   output logic [Width-1:0]         csr_wr_data_o,
   input  logic [NumRegs*Width-1:0] csr_rd_data_i,
   input  logic [NumRegs-1:0]       csr_rd_error_i,
   output logic [7:0]               err_count_o
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } state_t;

   localparam logic [1:0] OpRw = 2'b01;
   localparam logic [1:0] OpRs = 2'b10;
   localparam logic [1:0] OpRc = 2'b11;
   localparam logic [AddrW:0] NumRegsW = (AddrW + 1)'(NumRegs);

   state_t state_q, state_d;

   logic [1:0]       op_q;
   logic [AddrW-1:0] addr_q;
   logic [Width-1:0] data_q;
   logic [Width-1:0] old_q;
   logic [Width-1:0] new_q;
   logic             ierr_q;
   logic             err_q;
   logic [7:0]       err_count_q;

   logic [Width-1:0] rd_sel;
   logic             ierr_sel;
   logic [Width-1:0] new_d;
   logic             addr_legal;
   logic             op_legal;
   logic             do_write;

   assign addr_legal = ({1'b0, addr_q} < NumRegsW);
   assign op_legal   = (op_q != 2'b00);

   // Mask-type ops with an empty mask would rewrite the same value, so they skip the strobe.
   assign do_write = op_legal && addr_legal && !ierr_q &&
                     !(((op_q == OpRs) || (op_q == OpRc)) && (data_q == '0));

   // Mux the addressed register's read data and integrity flag; illegal addresses select nothing.
   always_comb begin
      rd_sel   = '0;
      ierr_sel = 1'b0;
      for (int k = 0; k < NumRegs; k++) begin
         if (addr_q == AddrW'(k)) begin
            rd_sel   = csr_rd_data_i[k*Width +: Width];
            ierr_sel = csr_rd_error_i[k];
         end
      end
   end

   always_comb begin
      new_d = rd_sel;
      case (op_q)
         OpRw:    new_d = data_q;
         OpRs:    new_d = rd_sel | data_q;
         OpRc:    new_d = rd_sel & ~data_q;
         default: new_d = rd_sel;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q        <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         old_q       <= '0;
         new_q       <= '0;
         ierr_q      <= 1'b0;
         err_q       <= 1'b0;
         err_count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  op_q   <= req_op_i;
                  addr_q <= req_addr_i;
                  data_q <= req_data_i;
               end
            end
            READ: begin
               old_q  <= addr_legal ? rd_sel : '0;
               new_q  <= new_d;
               ierr_q <= addr_legal && ierr_sel;
               err_q  <= !op_legal || !addr_legal || ierr_sel;
            end
            WRITE: begin
               if (ierr_q && (err_count_q != 8'hFF)) begin
                  err_count_q <= err_count_q + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next state and all handshake/strobe outputs decode straight from the state register.
   always_comb begin
      state_d       = state_q;
      req_ready_o   = 1'b0;
      rsp_valid_o   = 1'b0;
      rsp_rdata_o   = '0;
      rsp_err_o     = 1'b0;
      csr_wr_en_o   = '0;
      csr_wr_data_o = '0;
      case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               state_d = READ;
            end
         end
         READ: begin
            state_d = WRITE;
         end
         WRITE: begin
            csr_wr_data_o = new_q;
            if (do_write) begin
               for (int k = 0; k < NumRegs; k++) begin
                  csr_wr_en_o[k] = (addr_q == AddrW'(k));
               end
            end
            state_d = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            rsp_rdata_o = old_q;
            rsp_err_o   = err_q;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign err_count_o = err_count_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural csr bank attached.
// Expected values are hand-computed per vector.
module tb_csr_access_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'b00;
   logic [3:0]  req_addr = 4'd0;
   logic [31:0] req_data = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  wr_en;
   logic [31:0] wr_data;
   logic [255:0] rd_data_bus;
   logic [7:0]  rd_err = 8'h00;
   logic [7:0]  err_count;

   logic [31:0] regs [8];
   int          cyc = 0;
   int          accept_cyc = 0;
   int          strobe_count = 0;
   int          strobe_cycle = 0;
   logic [7:0]  strobe_mask = 8'h00;
   logic        multi_hot = 1'b0;
   int          rsp_cycle = 0;
   logic [31:0] got_rdata = 32'd0;
   logic        got_err = 1'b0;
   logic        hold_stable = 1'b0;
   int          check_count = 0;
   int          pass_count = 0;

   csr_access_ctrl #(.Width(32), .NumRegs(8), .AddrW(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_op_i       (req_op),
      .req_addr_i     (req_addr),
      .req_data_i     (req_data),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_rdata_o    (rsp_rdata),
      .rsp_err_o      (rsp_err),
      .csr_wr_en_o    (wr_en),
      .csr_wr_data_o  (wr_data),
      .csr_rd_data_i  (rd_data_bus),
      .csr_rd_error_i (rd_err),
      .err_count_o    (err_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural csr bank: registers take the shared write data on their strobe.
   always @(posedge clk) begin
      for (int k = 0; k < 8; k++) begin
         if (rst) regs[k] <= 32'd0;
         else if (wr_en[k]) regs[k] <= wr_data;
      end
   end

   always_comb begin
      for (int k = 0; k < 8; k++) rd_data_bus[k*32 +: 32] = regs[k];
   end

   always @(negedge clk) begin
      if (wr_en != 8'h00) begin
         strobe_count = strobe_count + 1;
         strobe_mask  = wr_en;
         strobe_cycle = cyc - accept_cyc + 1;
      end
      if ($countones(wr_en) > 1) multi_hot = 1'b1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         pass_count++;
      end
   endtask

   // One request from IDLE through response handshake; hold > 0 stalls the response for that many cycles.
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] addr,
                                input logic [31:0] data, input int hold);
      logic seen;
      logic stable;
      strobe_count = 0;
      strobe_mask  = 8'h00;
      strobe_cycle = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_data  = data;
      rsp_ready = (hold == 0);
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      req_valid  = 1'b0;
      req_op     = 2'b01;
      req_addr   = 4'd7;
      req_data   = 32'hA5A5_5A5A;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      if (!seen) begin
         checkOutput("rsp_timeout", 32'd0, 32'd1);
         rsp_ready = 1'b1;
      end else begin
         rsp_cycle = cyc - accept_cyc + 1;
         got_rdata = rsp_rdata;
         got_err   = rsp_err;
         if (hold > 0) begin
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
               @(negedge clk);
               if (rsp_valid !== 1'b1 || rsp_rdata !== got_rdata ||
                   rsp_err !== got_err || req_ready !== 1'b0) stable = 1'b0;
            end
            hold_stable = stable;
            rsp_ready = 1'b1;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic rsp_seen;
      $display("[TB] starting csr_access_ctrl bench");
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
      checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
      checkOutput("rst_wr_data", wr_data, 32'd0);
      checkOutput("rst_err_count", 32'(err_count), 32'd0);
      rst = 1'b0;

      applyStimulus(2'b01, 4'd2, 32'hDEAD_BEEF, 0);
      checkOutput("rw_rdata", got_rdata, 32'd0);
      checkOutput("rw_err", 32'(got_err), 32'd0);
      checkOutput("rw_strobe_count", 32'(strobe_count), 32'd1);
      checkOutput("rw_strobe_mask", 32'(strobe_mask), 32'h04);
      checkOutput("rw_strobe_cycle", 32'(strobe_cycle), 32'd2);
      checkOutput("rw_rsp_cycle", 32'(rsp_cycle), 32'd3);
      checkOutput("rw_reg2", regs[2], 32'hDEAD_BEEF);

      applyStimulus(2'b10, 4'd2, 32'd0, 0);
      checkOutput("rs0_rdata", got_rdata, 32'hDEAD_BEEF);
      checkOutput("rs0_err", 32'(got_err), 32'd0);
      checkOutput("rs0_strobe_count", 32'(strobe_count), 32'd0);

      applyStimulus(2'b01, 4'd1, 32'h0000_00F0, 0);
      applyStimulus(2'b10, 4'd1, 32'h0000_000F, 0);
      checkOutput("rs_rdata", got_rdata, 32'h0000_00F0);
      checkOutput("rs_reg1", regs[1], 32'h0000_00FF);
      checkOutput("rs_strobe_mask", 32'(strobe_mask), 32'h02);
      applyStimulus(2'b11, 4'd1, 32'h0000_00F0, 0);
      checkOutput("rc_rdata", got_rdata, 32'h0000_00FF);
      checkOutput("rc_reg1", regs[1], 32'h0000_000F);
      checkOutput("rc_err", 32'(got_err), 32'd0);

      applyStimulus(2'b01, 4'd9, 32'h1111_1111, 0);
      checkOutput("badaddr_err", 32'(got_err), 32'd1);
      checkOutput("badaddr_rdata", got_rdata, 32'd0);
      checkOutput("badaddr_strobe", 32'(strobe_count), 32'd0);

      applyStimulus(2'b01, 4'd0, 32'h0000_0055, 0);
      applyStimulus(2'b00, 4'd0, 32'hFFFF_FFFF, 0);
      checkOutput("badop_err", 32'(got_err), 32'd1);
      checkOutput("badop_rdata", got_rdata, 32'h0000_0055);
      checkOutput("badop_strobe", 32'(strobe_count), 32'd0);
      checkOutput("badop_reg0", regs[0], 32'h0000_0055);

      applyStimulus(2'b01, 4'd3, 32'h0000_A5A5, 0);
      rd_err = 8'h08;
      applyStimulus(2'b01, 4'd3, 32'h0000_1234, 0);
      checkOutput("ierr_err", 32'(got_err), 32'd1);
      checkOutput("ierr_rdata", got_rdata, 32'h0000_A5A5);
      checkOutput("ierr_strobe", 32'(strobe_count), 32'd0);
      checkOutput("ierr_count1", 32'(err_count), 32'd1);
      for (int i = 0; i < 299; i++) applyStimulus(2'b01, 4'd3, 32'h0000_1234, 0);
      checkOutput("ierr_count_sat", 32'(err_count), 32'd255);
      checkOutput("ierr_reg3", regs[3], 32'h0000_A5A5);
      rd_err = 8'h00;

      applyStimulus(2'b01, 4'd4, 32'h0000_0077, 10);
      checkOutput("bp_stable", 32'(hold_stable), 32'd1);
      checkOutput("bp_strobe_count", 32'(strobe_count), 32'd1);
      checkOutput("bp_reg4", regs[4], 32'h0000_0077);
      @(negedge clk);
      checkOutput("bp_idle_ready", 32'(req_ready), 32'd1);
      checkOutput("bp_idle_valid", 32'(rsp_valid), 32'd0);

      strobe_count = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 2'b01;
      req_addr  = 4'd5;
      req_data  = 32'h0000_0099;
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      req_valid  = 1'b0;
      rst        = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_ready", 32'(req_ready), 32'd1);
      checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
      rsp_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) rsp_seen = 1'b1;
      end
      checkOutput("midrst_rsp_valid", 32'(rsp_seen), 32'd0);
      checkOutput("midrst_strobe", 32'(strobe_count), 32'd0);
      checkOutput("midrst_reg5", regs[5], 32'd0);

      checkOutput("onehot_strobe", 32'(multi_hot), 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
